// File: rtl/key_debounce_capture_if.sv
// Key conditioning bus: raw pins and capture-clear in; debounced level, strobes,
// sticky capture and interrupt out.
interface key_debounce_capture_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                cap_clr;
  logic [NUM_KEYS-1:0] cap_clr_mask;
  logic [NUM_KEYS-1:0] key_cap;
  logic                irq;

  modport master (
    output key_in, cap_clr, cap_clr_mask,
    input  key_level, key_press, key_release, key_cap, irq
  );

  modport slave (
    input  key_in, cap_clr, cap_clr_mask,
    output key_level, key_press, key_release, key_cap, irq
  );
endinterface

// File: rtl/key_debounce_capture.sv
// Per-key synchroniser, counter debouncer and press/release strobes, plus a sticky
// write-1-to-clear press-capture register driving a registered interrupt.
module key_debounce_capture #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input logic                    clk,
  input logic                    reset_n,
  key_debounce_capture_if.slave  bus
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } deb_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync_meta;
  logic [NUM_KEYS-1:0] sync;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rel;
  logic [NUM_KEYS-1:0] cap;
  logic [NUM_KEYS-1:0] clr_bits;
  logic                irq_q;

  // Released (high) is the idle pin level, so the synchroniser resets to 1 and a
  // key held down through reset is seen as a fresh press afterwards.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '1;
      sync      <= '1;
    end else begin
      sync_meta <= bus.key_in;
      sync      <= sync_meta;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    deb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             lvl_q;
    logic             press_q;
    logic             rel_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state   <= ST_STABLE;
        cnt     <= '0;
        lvl_q   <= 1'b1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          ST_STABLE: begin
            cnt <= '0;
            if (sync[i] != lvl_q) begin
              state <= ST_COUNT;
              cnt   <= CNT_W'(1);
            end
          end
          ST_COUNT: begin
            if (sync[i] == lvl_q) begin
              state <= ST_STABLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              // Strobes register alongside the new level so they line up with it.
              lvl_q   <= ~lvl_q;
              press_q <= lvl_q;
              rel_q   <= ~lvl_q;
              cnt     <= '0;
              state   <= ST_STABLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= ST_STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign level[i] = lvl_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
  end

  assign clr_bits = bus.cap_clr ? bus.cap_clr_mask : '0;

  // A press arriving in the same cycle as its clear must not be lost: set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap   <= '0;
      irq_q <= 1'b0;
    end else begin
      cap   <= (cap & ~clr_bits) | press;
      irq_q <= |cap;
    end
  end

  assign bus.key_level   = level;
  assign bus.key_press   = press;
  assign bus.key_release = rel;
  assign bus.key_cap     = cap;
  assign bus.irq         = irq_q;

endmodule
